// File: rtl/dispense_if.sv
// Handshake/status bundle between the vending front end and dispense_controller.
interface dispense_if;
   logic       div_clk_i;
   logic       req_i;
   logic       coin_ok_i;
   logic [1:0] sel_i;
   logic       drop_i;
   logic       clr_i;
   logic [3:0] motor_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   modport master (
      output div_clk_i, req_i, coin_ok_i, sel_i, drop_i, clr_i,
      input  motor_o, busy_o, done_o, err_o
   );

   modport slave (
      input  div_clk_i, req_i, coin_ok_i, sel_i, drop_i, clr_i,
      output motor_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/dispense_controller.sv
// Dispense motor sequencer with drop detection and timeout fault.
// Optional DISPENSE_RETRY_EN: one automatic motor retry before faulting.
module dispense_controller #(
   parameter int unsigned RUN_TICKS     = 3,
   parameter int unsigned TIMEOUT_TICKS = 10
) (
   input logic     clock_test,
   input logic     rst,
   dispense_if.slave bus
);

   typedef enum logic [2:0] {IDLE, RUN, WAIT_DROP, DONE, FAULT} state_t;

   localparam logic [7:0] RUN_LAST = 8'(RUN_TICKS - 1);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_TICKS - 1);

   state_t     state, state_n;
   logic       div_q;
   logic       tick;
   logic [7:0] cnt, cnt_n;
   logic [1:0] sel_q, sel_n;
   logic [3:0] motor_n;
   logic       busy_n, done_n, err_n;
`ifdef DISPENSE_RETRY_EN
   logic       retry_q, retry_n;
`endif

   assign tick = bus.div_clk_i & ~div_q;

   always_ff @(posedge clock_test) begin
      if (rst) begin
         state       <= IDLE;
         div_q       <= 1'b0;
         cnt         <= '0;
         sel_q       <= '0;
         bus.motor_o <= '0;
         bus.busy_o  <= 1'b0;
         bus.done_o  <= 1'b0;
         bus.err_o   <= 1'b0;
`ifdef DISPENSE_RETRY_EN
         retry_q     <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         div_q       <= bus.div_clk_i;
         cnt         <= cnt_n;
         sel_q       <= sel_n;
         bus.motor_o <= motor_n;
         bus.busy_o  <= busy_n;
         bus.done_o  <= done_n;
         bus.err_o   <= err_n;
`ifdef DISPENSE_RETRY_EN
         retry_q     <= retry_n;
`endif
      end
   end

   // Drop detection is checked before the tick so it wins over a terminal count.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sel_n   = sel_q;
`ifdef DISPENSE_RETRY_EN
      retry_n = retry_q;
`endif
      case (state)
         IDLE: begin
            if (bus.req_i && bus.coin_ok_i) begin
               sel_n   = bus.sel_i;
               cnt_n   = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            if (bus.drop_i) begin
               cnt_n   = '0;
               state_n = DONE;
            end else if (tick) begin
               if (cnt == RUN_LAST) begin
                  cnt_n   = '0;
                  state_n = WAIT_DROP;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
         end
         WAIT_DROP: begin
            if (bus.drop_i) begin
               cnt_n   = '0;
               state_n = DONE;
            end else if (tick) begin
               if (cnt == TO_LAST) begin
                  cnt_n   = '0;
`ifdef DISPENSE_RETRY_EN
                  if (!retry_q) begin
                     retry_n = 1'b1;
                     state_n = RUN;
                  end else begin
                     state_n = FAULT;
                  end
`else
                  state_n = FAULT;
`endif
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
         end
         DONE: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
         FAULT: begin
            if (bus.clr_i) begin
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
`ifdef DISPENSE_RETRY_EN
      if (state_n == IDLE) retry_n = 1'b0;
`endif
   end

   // Outputs are decoded from the next state so the registered copies track state.
   always_comb begin
      motor_n = '0;
      busy_n  = (state_n != IDLE);
      done_n  = (state_n == DONE);
      err_n   = (state_n == FAULT);
      if (state_n == RUN) motor_n = 4'b0001 << sel_n;
   end

endmodule

// File: tb/tb_dispense_controller.sv
// Scoreboard bench for dispense_controller: stimulus queues expected done/fault events.
module tb_dispense_controller;

   typedef struct {
      bit         is_fault;
      logic [3:0] motor;
      int         cycles;
   } exp_t;

   logic clock_test;
   logic rst;
   int   ph;
   int   total;
   int   passed;
   exp_t q[$];

   dispense_if bus();

   dispense_controller #(.RUN_TICKS(3), .TIMEOUT_TICKS(4)) dut (
      .clock_test(clock_test),
      .rst       (rst),
      .bus       (bus)
   );

   initial begin
      clock_test = 1'b0;
      forever #5 clock_test = ~clock_test;
   end

   task automatic check(input string name, input int act, input int exp_v);
      total++;
      if (act == exp_v) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
   endtask

   // One clock: advance at the falling edge, slow clock has an 8-cycle period.
   task automatic cycle();
      @(negedge clock_test);
      bus.div_clk_i = ((ph % 8) >= 4);
      ph++;
   endtask

   task automatic cycles(input int n);
      repeat (n) cycle();
   endtask

   task automatic start(input logic [1:0] s);
      ph = 0;
      cycle();
      bus.req_i     = 1'b1;
      bus.coin_ok_i = 1'b1;
      bus.sel_i     = s;
      cycle();
      bus.req_i     = 1'b0;
      bus.coin_ok_i = 1'b0;
   endtask

   task automatic expect_ev(input bit f, input logic [3:0] m, input int c);
      exp_t e;
      e.is_fault = f;
      e.motor    = m;
      e.cycles   = c;
      q.push_back(e);
   endtask

   // Monitor: counts motor-on cycles per operation and checks each done/fault event.
   initial begin
      int         oncnt;
      logic [3:0] last;
      logic       err_prev;
      exp_t       e;
      oncnt    = 0;
      last     = '0;
      err_prev = 1'b0;
      forever begin
         @(negedge clock_test);
         if (bus.done_o || (bus.err_o && !err_prev)) begin
            if (q.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               e = q.pop_front();
               check("event_is_fault", int'(bus.err_o), int'(e.is_fault));
               check("motor_value", int'(last), int'(e.motor));
               check("motor_cycles", oncnt, e.cycles);
            end
            oncnt = 0;
         end else if (!bus.busy_o) begin
            oncnt = 0;
         end else if (bus.motor_o != 4'd0) begin
            oncnt++;
            last = bus.motor_o;
         end
         err_prev = bus.err_o;
      end
   end

   initial begin
      int t_fault;
      total  = 0;
      passed = 0;
      ph     = 0;
      rst    = 1'b1;
      bus.div_clk_i = 1'b0;
      bus.req_i     = 1'b0;
      bus.coin_ok_i = 1'b0;
      bus.sel_i     = 2'd0;
      bus.drop_i    = 1'b0;
      bus.clr_i     = 1'b0;
      cycles(3);
      check("reset_motor", int'(bus.motor_o), 0);
      check("reset_busy", int'(bus.busy_o), 0);
      check("reset_done", int'(bus.done_o), 0);
      check("reset_err", int'(bus.err_o), 0);
      rst = 1'b0;
      cycles(4);

      // Nominal: drop after the 2nd motor tick.
      start(2'd2);
      expect_ev(1'b0, 4'b0100, 14);
      cycles(13);
      bus.drop_i = 1'b1;
      cycle();
      bus.drop_i = 1'b0;
      cycle();
      check("nominal_busy_after", int'(bus.busy_o), 0);
      check("nominal_done_single", int'(bus.done_o), 0);
      cycles(4);

      // Timeout to FAULT, then clear.
`ifdef DISPENSE_RETRY_EN
      t_fault = 109;
      expect_ev(1'b1, 4'b0010, 44);
`else
      t_fault = 53;
      expect_ev(1'b1, 4'b0010, 20);
`endif
      start(2'd1);
      cycles(t_fault + 4);
      check("fault_err_held", int'(bus.err_o), 1);
      check("fault_busy_held", int'(bus.busy_o), 1);
      bus.clr_i = 1'b1;
      cycle();
      bus.clr_i = 1'b0;
      check("clear_err", int'(bus.err_o), 0);
      check("clear_busy", int'(bus.busy_o), 0);
      cycles(4);

      // Drop on the same cycle as the terminal timeout tick.
      start(2'd0);
      expect_ev(1'b0, 4'b0001, 20);
      cycles(51);
      bus.drop_i = 1'b1;
      cycle();
      bus.drop_i = 1'b0;
      check("simul_err_low", int'(bus.err_o), 0);
      cycle();
      check("simul_busy_after", int'(bus.busy_o), 0);
      check("simul_err_after", int'(bus.err_o), 0);
      cycles(4);

      // Request without payment is ignored.
      bus.req_i     = 1'b1;
      bus.coin_ok_i = 1'b0;
      cycles(10);
      check("nocoin_busy", int'(bus.busy_o), 0);
      bus.req_i = 1'b0;
      cycles(2);

      // Request during RUN with another select does not change the motor.
      start(2'd3);
      expect_ev(1'b0, 4'b1000, 8);
      cycles(4);
      bus.req_i     = 1'b1;
      bus.coin_ok_i = 1'b1;
      bus.sel_i     = 2'd0;
      cycle();
      check("run_req_motor", int'(bus.motor_o), 8);
      bus.req_i     = 1'b0;
      bus.coin_ok_i = 1'b0;
      cycles(2);
      bus.drop_i = 1'b1;
      cycle();
      bus.drop_i = 1'b0;
      cycles(3);

      // Reset during RUN, then a fresh request.
      start(2'd0);
      cycles(4);
      rst = 1'b1;
      cycle();
      check("midrst_motor", int'(bus.motor_o), 0);
      check("midrst_busy", int'(bus.busy_o), 0);
      rst = 1'b0;
      cycles(2);
      start(2'd0);
      expect_ev(1'b0, 4'b0001, 6);
      cycles(5);
      bus.drop_i = 1'b1;
      cycle();
      bus.drop_i = 1'b0;
      cycles(3);

`ifdef DISPENSE_RETRY_EN
      // Drop during the retry run.
      start(2'd2);
      expect_ev(1'b0, 4'b0100, 30);
      cycles(61);
      bus.drop_i = 1'b1;
      cycle();
      bus.drop_i = 1'b0;
      cycles(3);
`endif

      cycles(5);
      check("pending_events", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dispense_controller.md
DISPENSE_CONTROLLER -- requirements
Module: dispense_controller

Interface
REQ-001 Parameter RUN_TICKS, default 3: slow ticks the selected motor is driven; legal 1..255.
REQ-002 Parameter TIMEOUT_TICKS, default 10: slow ticks allowed for drop detection after the motor stops; legal 1..255.
REQ-003 clock_test  input  1  system clock (internal oscillator); one clock only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 div_clk_i  input  1  divided slow clock from the clock divider, generated from clock_test.
REQ-006 req_i  input  1  dispense request, level, sampled only in IDLE.
REQ-007 coin_ok_i  input  1  payment accepted, qualifies req_i.
REQ-008 sel_i  input  2  item select, 0..3.
REQ-009 drop_i  input  1  drop sensor, high = item detected.
REQ-010 clr_i  input  1  fault clear.
REQ-011 motor_o  output  4  one-hot motor drive.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 done_o  output  1  single-cycle success pulse.
REQ-014 err_o  output  1  fault flag, held while in FAULT.

Function
REQ-015 The block SHALL register div_clk_i into div_q and form tick = div_clk_i AND NOT div_q: one clock_test cycle per slow rising edge.
REQ-016 The FSM states SHALL be IDLE, RUN, WAIT_DROP, DONE and FAULT; all outputs SHALL be registered.
REQ-017 In IDLE with req_i=1 and coin_ok_i=1, the block SHALL latch sel_i into sel_q, clear the 8-bit tick counter and enter RUN on the next edge.
REQ-018 req_i outside IDLE, and req_i without coin_ok_i, SHALL be ignored.
REQ-019 In RUN, motor_o SHALL equal 1 shifted left by sel_q; every other state SHALL drive motor_o=0.
REQ-020 In RUN, each tick SHALL increment the counter; when the RUN_TICKS-th tick arrives, the block SHALL clear the counter and enter WAIT_DROP.
REQ-021 drop_i=1 in RUN or WAIT_DROP SHALL cause an immediate transition to DONE, which cuts the motor on the next edge.
REQ-022 In WAIT_DROP, the TIMEOUT_TICKS-th tick without drop_i SHALL cause a transition to FAULT.
REQ-023 If drop_i and a terminal tick occur in the same cycle, DONE SHALL win.
REQ-024 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE; a new request is accepted in the following cycle.
REQ-025 FAULT SHALL hold err_o=1 and busy_o=1 until clr_i=1, then return to IDLE with err_o=0 on the next edge.
REQ-026 clr_i outside FAULT SHALL be ignored.
REQ-027 The counter SHALL never wrap, because terminal counts are at most 255 and the counter is cleared on every state entry.

Reset
REQ-028 When rst=1 at a clock_test edge, the block SHALL set state=IDLE, div_q=0, counter=0, sel_q=0, motor_o=0, busy_o=0, done_o=0 and err_o=0.
REQ-029 rst SHALL override every other input, including mid-RUN; the motor SHALL be off in the cycle after the reset edge.
REQ-030 In the first cycle after reset, an already-high div_clk_i SHALL produce a tick.

Configuration
REQ-031 With macro DISPENSE_RETRY_EN defined, the first timeout of a request SHALL return to RUN with the counter cleared, sel_q kept and a retry flag set; a second timeout SHALL enter FAULT.
REQ-032 The retry flag SHALL clear on reset and on entry to IDLE.
REQ-033 Without DISPENSE_RETRY_EN, the first timeout SHALL enter FAULT directly and no retry flag SHALL be synthesized.

Verification
REQ-034 Nominal: RUN_TICKS=3, div_clk_i period 8 cycles, req_i=1, coin_ok_i=1, sel_i=2, drop_i after the 2nd motor tick -> motor_o=4'b0100 until the drop, then one done_o pulse and busy_o=0.
REQ-035 Timeout: TIMEOUT_TICKS=4, drop_i held 0 -> motor on for 3 ticks, err_o=1 after the 4th WAIT_DROP tick; clr_i pulse -> IDLE with err_o=0.
REQ-036 Simultaneous events: drop_i on the same cycle as the 4th timeout tick -> done_o=1 and err_o stays 0.
REQ-037 Ignored inputs: req_i with coin_ok_i=0 -> busy_o stays 0; req_i during RUN with a different sel_i -> motor_o unchanged.
REQ-038 Reset mid-operation: rst=1 during RUN -> next cycle motor_o=0 and busy_o=0, and a new request is accepted afterwards.
REQ-039 Retry (DISPENSE_RETRY_EN defined): with no drop, the motor runs twice for 3 ticks each before err_o=1; a drop during the retry -> done_o=1.
